tx_frame_packer: RTL and testbench

TX_FRAME_PACKER -- requirements
Module: tx_frame_packer

---
 rtl/tx_frame_packer_pkg.sv | 36 +++
 rtl/tx_frame_packer.sv | 88 ++++++++
 tb/tb_tx_frame_packer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_packer_pkg.sv
// rtl/tx_frame_packer_pkg.sv - shared frame format constants, FSM state type and byte builder
package tx_frame_packer_pkg;

    localparam logic [3:0]  HDR_NIBBLE = 4'hA;
    localparam int unsigned FRAME_LEN  = 4;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PHI  = 3'd2,
        ST_PLO  = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

    // Byte idx of the frame for a held entry; the last byte is the XOR checksum of the first three.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [2:0]  id,
        input logic [15:0] payload,
        input logic [1:0]  idx
    );
        logic [BYTE_W-1:0] b0;
        logic [BYTE_W-1:0] b1;
        logic [BYTE_W-1:0] b2;
        b0 = {HDR_NIBBLE, 1'b0, id};
        b1 = payload[15:8];
        b2 = payload[7:0];
        case (idx)
            2'd0:    frame_byte = b0;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
            default: frame_byte = b0 ^ b1 ^ b2;
        endcase
    endfunction

endpackage

// File: rtl/tx_frame_packer.sv
// rtl/tx_frame_packer.sv - packs ordered TX entries into 4-byte link frames with SOF/EOF and checksum
module tx_frame_packer
    import tx_frame_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [2:0]        in_id_i,
    input  logic [15:0]       in_payload_i,
    output logic              in_ready_o,
    output logic              link_valid_o,
    output logic [BYTE_W-1:0] link_data_o,
    output logic              link_sof_o,
    output logic              link_eof_o,
    input  logic              link_ready_i,
    output logic [15:0]       frames_sent_o,
    output logic              idle_o
);

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  id_q;
    logic [15:0] payload_q;
    logic [15:0] frames_q;
    logic [15:0] frames_d;
    logic        in_xfer;
    logic        link_xfer;
    logic [1:0]  byte_idx;

    // A new entry may land in the CHK cycle so back-to-back frames leave no gap.
    assign in_ready_o   = (state_q == ST_IDLE) | ((state_q == ST_CHK) & link_ready_i);
    assign link_valid_o = (state_q != ST_IDLE);
    assign in_xfer      = in_valid_i & in_ready_o;
    assign link_xfer    = link_valid_o & link_ready_i;

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        case (state_q)
            ST_IDLE: if (in_xfer)   state_d = ST_HDR;
            ST_HDR:  if (link_xfer) state_d = ST_PHI;
            ST_PHI:  if (link_xfer) state_d = ST_PLO;
            ST_PLO:  if (link_xfer) state_d = ST_CHK;
            ST_CHK: begin
                if (link_xfer) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = in_xfer ? ST_HDR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_idx = 2'd0;
        case (state_q)
            ST_PHI:  byte_idx = 2'd1;
            ST_PLO:  byte_idx = 2'd2;
            ST_CHK:  byte_idx = 2'(FRAME_LEN - 1);
            default: byte_idx = 2'd0;
        endcase
    end

    assign link_data_o   = link_valid_o ? frame_byte(id_q, payload_q, byte_idx) : '0;
    assign link_sof_o    = (state_q == ST_HDR);
    assign link_eof_o    = (state_q == ST_CHK);
    assign frames_sent_o = frames_q;
    assign idle_o        = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            frames_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
        end
    end

    // Holding register is only loaded on acceptance, so it stays frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            id_q      <= in_id_i;
            payload_q <= in_payload_i;
        end
    end

endmodule

// File: tb/tb_tx_frame_packer.sv
// tb/tb_tx_frame_packer.sv - self-checking bench for tx_frame_packer
module tb_tx_frame_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid_i;
    logic [2:0]  in_id_i;
    logic [15:0] in_payload_i;
    logic        in_ready_o;
    logic        link_valid_o;
    logic [7:0]  link_data_o;
    logic        link_sof_o;
    logic        link_eof_o;
    logic        link_ready_i;
    logic [15:0] frames_sent_o;
    logic        idle_o;

    int tests = 0;
    int fails = 0;

    tx_frame_packer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid_i    (in_valid_i),
        .in_id_i       (in_id_i),
        .in_payload_i  (in_payload_i),
        .in_ready_o    (in_ready_o),
        .link_valid_o  (link_valid_o),
        .link_data_o   (link_data_o),
        .link_sof_o    (link_sof_o),
        .link_eof_o    (link_eof_o),
        .link_ready_i  (link_ready_i),
        .frames_sent_o (frames_sent_o),
        .idle_o        (idle_o)
    );

    always #5 clk = ~clk;

    // Observation vector: {valid, data, sof, eof, in_ready, idle, frames}
    typedef struct {
        logic        iv;
        logic [2:0]  id;
        logic [15:0] pl;
        logic        lr;
        logic [28:0] exp;
    } vec_t;

    vec_t vt[23];

    logic [7:0]  mq[$];
    logic [15:0] m_frames;

    function automatic vec_t mk(input logic iv, input logic [2:0] id, input logic [15:0] pl,
                                input logic lr, input logic v, input logic [7:0] d,
                                input logic s, input logic e, input logic r, input logic idl,
                                input logic [15:0] f);
        vec_t x;
        x.iv  = iv;
        x.id  = id;
        x.pl  = pl;
        x.lr  = lr;
        x.exp = {v, d, s, e, r, idl, f};
        return x;
    endfunction

    function automatic logic [28:0] dut_obs();
        return {link_valid_o, link_data_o, link_sof_o, link_eof_o, in_ready_o, idle_o, frames_sent_o};
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a queue of the bytes still owed on the link for the current frame.
    function automatic logic [28:0] model_obs(input logic lr);
        logic       v;
        logic [7:0] d;
        v = (mq.size() > 0);
        d = v ? mq[0] : 8'h00;
        return {v, d, 1'(mq.size() == 4), 1'(mq.size() == 1),
                1'((mq.size() == 0) || (mq.size() == 1 && lr)), 1'(mq.size() == 0), m_frames};
    endfunction

    task automatic model_step(input logic iv, input logic [2:0] id, input logic [15:0] pl, input logic lr);
        logic       rdy;
        logic [7:0] b0;
        rdy = (mq.size() == 0) || (mq.size() == 1 && lr);
        if (mq.size() > 0 && lr) begin
            if (mq.size() == 1) m_frames = m_frames + 16'd1;
            void'(mq.pop_front());
        end
        if (iv && rdy) begin
            b0 = 8'hA0 | {5'd0, id};
            mq.push_back(b0);
            mq.push_back(pl[15:8]);
            mq.push_back(pl[7:0]);
            mq.push_back(b0 ^ pl[15:8] ^ pl[7:0]);
        end
    endtask

    task automatic model_cycle(input logic iv, input logic [2:0] id, input logic [15:0] pl,
                               input logic lr, input string name);
        in_valid_i   = iv;
        in_id_i      = id;
        in_payload_i = pl;
        link_ready_i = lr;
        @(negedge clk);
        check(name, dut_obs(), model_obs(lr));
        model_step(iv, id, pl, lr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        in_valid_i   = 1'b0;
        in_id_i      = 3'd0;
        in_payload_i = 16'h0;
        link_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_frames = 16'h0;
    endtask

    initial begin
        vt[0]  = mk(1, 5, 16'h1234, 1, 0, 8'h00, 0, 0, 1, 1, 0);
        vt[1]  = mk(0, 0, 16'h0000, 1, 1, 8'hA5, 1, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 16'h0000, 1, 1, 8'h12, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 16'h0000, 1, 1, 8'h34, 0, 0, 0, 0, 0);
        vt[4]  = mk(0, 0, 16'h0000, 1, 1, 8'h83, 0, 1, 1, 0, 0);
        vt[5]  = mk(1, 5, 16'h1234, 1, 0, 8'h00, 0, 0, 1, 1, 1);
        vt[6]  = mk(0, 0, 16'h0000, 1, 1, 8'hA5, 1, 0, 0, 0, 1);
        vt[7]  = mk(0, 0, 16'h0000, 0, 1, 8'h12, 0, 0, 0, 0, 1);
        vt[8]  = mk(1, 2, 16'hBEEF, 0, 1, 8'h12, 0, 0, 0, 0, 1);
        vt[9]  = mk(0, 0, 16'h0000, 0, 1, 8'h12, 0, 0, 0, 0, 1);
        vt[10] = mk(0, 0, 16'h0000, 1, 1, 8'h12, 0, 0, 0, 0, 1);
        vt[11] = mk(0, 0, 16'h0000, 1, 1, 8'h34, 0, 0, 0, 0, 1);
        vt[12] = mk(0, 0, 16'h0000, 1, 1, 8'h83, 0, 1, 1, 0, 1);
        vt[13] = mk(1, 0, 16'hFFFF, 1, 0, 8'h00, 0, 0, 1, 1, 2);
        vt[14] = mk(1, 7, 16'h0001, 1, 1, 8'hA0, 1, 0, 0, 0, 2);
        vt[15] = mk(1, 7, 16'h0001, 1, 1, 8'hFF, 0, 0, 0, 0, 2);
        vt[16] = mk(1, 7, 16'h0001, 1, 1, 8'hFF, 0, 0, 0, 0, 2);
        vt[17] = mk(1, 7, 16'h0001, 1, 1, 8'hA0, 0, 1, 1, 0, 2);
        vt[18] = mk(0, 0, 16'h0000, 1, 1, 8'hA7, 1, 0, 0, 0, 3);
        vt[19] = mk(0, 0, 16'h0000, 1, 1, 8'h00, 0, 0, 0, 0, 3);
        vt[20] = mk(0, 0, 16'h0000, 1, 1, 8'h01, 0, 0, 0, 0, 3);
        vt[21] = mk(0, 0, 16'h0000, 1, 1, 8'hA6, 0, 1, 1, 0, 3);
        vt[22] = mk(0, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 1, 1, 4);

        do_reset();
        @(negedge clk);
        check("reset_state", dut_obs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000});
        @(posedge clk);
        #1;

        // Single frame, backpressure in PHI, then back-to-back frames
        for (int i = 0; i < 23; i++) begin
            in_valid_i   = vt[i].iv;
            in_id_i      = vt[i].id;
            in_payload_i = vt[i].pl;
            link_ready_i = vt[i].lr;
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_obs(), vt[i].exp);
            @(posedge clk);
            #1;
        end

        // Idle input keeps everything quiet and the counter steady
        m_frames = 16'd4;
        mq.delete();
        for (int i = 0; i < 10; i++) model_cycle(1'b0, 3'd0, 16'h0, 1'b1, $sformatf("idle%0d", i));

        // Reset asserted while PLO is on the link
        model_cycle(1'b1, 3'd2, 16'hABCD, 1'b1, "mid_acc");
        model_cycle(1'b0, 3'd0, 16'h0, 1'b1, "mid_hdr");
        model_cycle(1'b0, 3'd0, 16'h0, 1'b1, "mid_phi");
        @(negedge clk);
        check("mid_plo", dut_obs(), {1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4});
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", dut_obs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_frames = 16'h0;
        for (int i = 0; i < 3; i++) model_cycle(1'b0, 3'd0, 16'h0, 1'b1, $sformatf("post_rst%0d", i));
        model_cycle(1'b1, 3'd6, 16'h5A3C, 1'b1, "new_acc");
        @(negedge clk);
        check("new_b0", dut_obs(), {1'b1, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(posedge clk);
        #1;
        model_step(1'b0, 3'd0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) model_cycle(1'b0, 3'd0, 16'h0, 1'b1, $sformatf("new_f%0d", i));

        // Counter wrap from a preloaded 16'hFFFF
        force dut.frames_q = 16'hFFFF;
        #1;
        release dut.frames_q;
        m_frames = 16'hFFFF;
        model_cycle(1'b1, 3'd1, 16'h0F0F, 1'b1, "wrap_acc");
        for (int i = 0; i < 5; i++) model_cycle(1'b0, 3'd0, 16'h0, 1'b1, $sformatf("wrap%0d", i));
        @(negedge clk);
        check("wrap_zero", {13'd0, frames_sent_o}, 29'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic iv;
            logic lr;
            iv = ($urandom_range(0, 3) != 0);
            lr = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            model_cycle(iv, 3'($urandom_range(0, 7)), 16'($urandom), lr, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
